sort_rle: RTL
=============

// Module: sort_rle
// PURPOSE
//  Run-length compressor placed directly downstream of the sort stage.
//  Consumes one sorted Avalon-ST packet and emits one record per distinct value: {value, count}.
//  Records are emitted in input order. Framing is preserved: sop on the first record, eop on the last.
//  Turns the sorter output into a compact histogram for later stages.
// PARAMETERS
//  DWIDTH       8     data width of the sample value
//  MAX_PKT_LEN  1024  maximum number of beats in one packet
//  CWIDTH       $clog2(MAX_PKT_LEN+1)  count width (derived; 11 by default)
// PORTS
//  clk_i                input   1       clock; all logic on the rising edge
//  rst_n_i              input   1       asynchronous reset, active-low
//  snk_data_i           input   DWIDTH  sorted sample from the sort stage
//  snk_startofpacket_i  input   1       first beat of packet
//  snk_endofpacket_i    input   1       last beat of packet
//  snk_valid_i          input   1       beat valid
//  snk_ready_o          output  1       block can accept a beat this cycle
//  src_data_o           output  DWIDTH  record value
//  src_count_o          output  CWIDTH  run length of the value, 1..MAX_PKT_LEN
//  src_startofpacket_o  output  1       first record of packet
//  src_endofpacket_o    output  1       last record of packet
//  src_valid_o          output  1       record valid
//  src_ready_i          input   1       downstream accepts the record
// BEHAVIOUR
//  Handshake and reset
//  - Avalon-ST, readyLatency 0: a beat or record transfers on a clock where valid && ready.
//  - Reset: every register and output clears to 0. snk_ready_o is held at 0 while rst_n_i is low
//    and for one cycle after release (registered enable).
//  Output stage
//  - The output is a single register slot. It is free when !src_valid_o || src_ready_i.
//  - Once src_valid_o is asserted, the outputs stay stable until the record is accepted.
//  States
//  - IDLE: no run in progress.
//  - ACCUM: a run is held as {cur_val, cur_cnt}.
//  - FLUSH: one pending eop record is held.
//  Ready rule
//  - snk_ready_o = enable && slot free && state != FLUSH.
//  Accepted beat in IDLE
//  - With sop: cur_val=data, cur_cnt=1, first_rec=1, go to ACCUM.
//  - Without sop: the beat is dropped.
//  Accepted beat in ACCUM
//  - data==cur_val: cur_cnt+1.
//  - data!=cur_val: emit {cur_val, cur_cnt, sop=first_rec}, clear first_rec, start a new run with
//    data and count 1.
//  - Saturation: if cur_cnt is already MAX_PKT_LEN, the run is emitted and a new run of the same
//    value starts.
//  Beat with eop (ACCUM, after applying the rule above)
//  - Same value: emit the run with eop=1, go to IDLE.
//  - Different value: the old run is emitted this cycle. The new run (count 1) is held, go to
//    FLUSH. In FLUSH it is emitted with eop=1 as soon as the slot is free, then go to IDLE.
//  - Single-beat packet (sop && eop): emit {data, 1, sop=1, eop=1}, stay in IDLE.
//  - Sop received in ACCUM (missing eop): the current run is discarded and a new packet starts.
//  Latency
//  - A record appears on src one cycle after the beat that terminates its run.
//  - With src_ready_i=1 throughput is 1 beat/cycle, except 1 stall cycle per FLUSH.
//  Mid-operation reset
//  - Asserting rst_n_i mid-packet drops src_valid_o immediately (async) and discards the partial
//    packet.
// TESTING
//  1. Input 3,3,5,7,7,7 (sop on the first beat, eop on the last), src_ready_i=1
//     -> (3,2,sop), (5,1), (7,3,eop).
//  2. Single beat 0x42 with sop and eop -> one record (0x42,1,sop,eop).
//  3. 1024 beats all 0xFF -> one record (0xFF,1024,sop,eop), no saturation split.
//  4. Case 1 with src_ready_i held low for 10 cycles mid-stream -> snk_ready_o=0, src outputs
//     stable, all records intact afterwards.
//  5. Input 1,2 with eop on 2 -> (1,1,sop), then FLUSH with snk_ready_o=0 for exactly 1 cycle,
//     then (2,1,eop).
//  6. rst_n_i pulsed low after 5 beats of a 100-beat packet -> src_valid_o=0 at once. The next
//     packet compresses correctly, with no stale count.
//  7. Scoreboard: random sorted packets of length 100-1000 with random valid/ready. Expanding the
//     records must reproduce the input exactly.

Source files
------------

// File: rtl/sort_rle.sv
`default_nettype none
// ============================================================================
// Module      : sort_rle
// Description : Run-length compressor for one sorted Avalon-ST packet at a
//               time. Emits one {value, count} record per distinct run, in
//               input order, with sop on the first record and eop on the last.
// Ports       : clk_i, rst_n_i            clock, async active-low reset
//               snk_*                     sorted sample stream (readyLatency 0)
//               src_*                     {value, count} record stream
// Revision    : 1.0 - initial release
// ============================================================================
module sort_rle #(
    parameter int DWIDTH      = 8,
    parameter int MAX_PKT_LEN = 1024,
    parameter int CWIDTH      = $clog2(MAX_PKT_LEN + 1)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [DWIDTH-1:0] snk_data_i,
    input  logic              snk_startofpacket_i,
    input  logic              snk_endofpacket_i,
    input  logic              snk_valid_i,
    output logic              snk_ready_o,
    output logic [DWIDTH-1:0] src_data_o,
    output logic [CWIDTH-1:0] src_count_o,
    output logic              src_startofpacket_o,
    output logic              src_endofpacket_o,
    output logic              src_valid_o,
    input  logic              src_ready_i
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    localparam logic [CWIDTH-1:0] c_max_cnt = CWIDTH'(MAX_PKT_LEN);
    localparam logic [CWIDTH-1:0] c_one     = CWIDTH'(1);

    logic [1:0]        r_state;
    logic [DWIDTH-1:0] r_cur_val;
    logic [CWIDTH-1:0] r_cur_cnt;
    logic              r_first_rec;
    logic              r_enable;

    logic [DWIDTH-1:0] r_src_data;
    logic [CWIDTH-1:0] r_src_count;
    logic              r_src_sop;
    logic              r_src_eop;
    logic              r_src_valid;

    logic              w_slot_free;
    logic              w_snk_ready;
    logic              w_accept;

    logic [1:0]        w_state_nxt;
    logic [DWIDTH-1:0] w_cur_val_nxt;
    logic [CWIDTH-1:0] w_cur_cnt_nxt;
    logic              w_first_nxt;
    logic              w_emit;
    logic [DWIDTH-1:0] w_emit_data;
    logic [CWIDTH-1:0] w_emit_cnt;
    logic              w_emit_sop;
    logic              w_emit_eop;

    // Output slot is free when empty or being drained this cycle.
    assign w_slot_free = !r_src_valid || src_ready_i;
    assign w_snk_ready = r_enable && w_slot_free && (r_state != S_FLUSH);
    assign w_accept    = snk_valid_i && w_snk_ready;

    always_comb begin
        w_state_nxt   = r_state;
        w_cur_val_nxt = r_cur_val;
        w_cur_cnt_nxt = r_cur_cnt;
        w_first_nxt   = r_first_rec;
        w_emit        = 1'b0;
        w_emit_data   = r_cur_val;
        w_emit_cnt    = r_cur_cnt;
        w_emit_sop    = r_first_rec;
        w_emit_eop    = 1'b0;

        if (r_state == S_FLUSH) begin
            // Pending single-beat run left over from a value change on the eop beat.
            if (w_slot_free) begin
                w_emit      = 1'b1;
                w_emit_eop  = 1'b1;
                w_first_nxt = 1'b0;
                w_state_nxt = S_IDLE;
            end
        end else if (w_accept) begin
            if (snk_startofpacket_i) begin
                // New packet; any run in progress (missing eop) is discarded.
                if (snk_endofpacket_i) begin
                    w_emit      = 1'b1;
                    w_emit_data = snk_data_i;
                    w_emit_cnt  = c_one;
                    w_emit_sop  = 1'b1;
                    w_emit_eop  = 1'b1;
                    w_first_nxt = 1'b0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cur_val_nxt = snk_data_i;
                    w_cur_cnt_nxt = c_one;
                    w_first_nxt   = 1'b1;
                    w_state_nxt   = S_ACCUM;
                end
            end else if (r_state == S_ACCUM) begin
                if ((snk_data_i == r_cur_val) && (r_cur_cnt != c_max_cnt)) begin
                    if (snk_endofpacket_i) begin
                        w_emit      = 1'b1;
                        w_emit_cnt  = r_cur_cnt + c_one;
                        w_emit_eop  = 1'b1;
                        w_first_nxt = 1'b0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_cur_cnt_nxt = r_cur_cnt + c_one;
                    end
                end else begin
                    // Value change or saturated count: close the old run.
                    w_emit        = 1'b1;
                    w_first_nxt   = 1'b0;
                    w_cur_val_nxt = snk_data_i;
                    w_cur_cnt_nxt = c_one;
                    if (snk_endofpacket_i) begin
                        w_state_nxt = S_FLUSH;
                    end
                end
            end
            // Beats without sop in IDLE are dropped.
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_enable    <= 1'b0;
            r_state     <= S_IDLE;
            r_cur_val   <= '0;
            r_cur_cnt   <= '0;
            r_first_rec <= 1'b0;
            r_src_data  <= '0;
            r_src_count <= '0;
            r_src_sop   <= 1'b0;
            r_src_eop   <= 1'b0;
            r_src_valid <= 1'b0;
        end else begin
            r_enable    <= 1'b1;
            r_state     <= w_state_nxt;
            r_cur_val   <= w_cur_val_nxt;
            r_cur_cnt   <= w_cur_cnt_nxt;
            r_first_rec <= w_first_nxt;
            if (w_emit) begin
                r_src_data  <= w_emit_data;
                r_src_count <= w_emit_cnt;
                r_src_sop   <= w_emit_sop;
                r_src_eop   <= w_emit_eop;
                r_src_valid <= 1'b1;
            end else if (src_ready_i) begin
                r_src_valid <= 1'b0;
            end
        end
    end

    assign snk_ready_o         = w_snk_ready;
    assign src_data_o          = r_src_data;
    assign src_count_o         = r_src_count;
    assign src_startofpacket_o = r_src_sop;
    assign src_endofpacket_o   = r_src_eop;
    assign src_valid_o         = r_src_valid;

endmodule
`default_nettype wire
